// File: rtl/data_pkg.sv
// Shared constants, derived widths and FSM state type for the lane_capture slice.
package data_pkg;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned LANES  = 8;
  localparam int unsigned ACC_W  = $clog2(LANES * DEPTH * (2**DW - 1) + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned RND    = LANES * DEPTH / 2;
  localparam int unsigned AVG_SH = $clog2(LANES * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FINISH,
    DONE
  } state_t;
endpackage

// File: rtl/lane_bank.sv
// One DEPTH x DW sample bank: single write port, registered read port (read-before-write).
module lane_bank #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/lane_capture.sv
// Captures a DEPTH-beat frame of eight lanes into banks, keeps a running sum and
// reports the rounded frame average. Optional sticky overflow port: OVF_FLAG_EN.
module lane_capture
  import data_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in0,
  input  logic [DW-1:0]    in1,
  input  logic [DW-1:0]    in2,
  input  logic [DW-1:0]    in3,
  input  logic [DW-1:0]    in4,
  input  logic [DW-1:0]    in5,
  input  logic [DW-1:0]    in6,
  input  logic [DW-1:0]    in7,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [2:0]       rd_lane,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             done,
`ifdef OVF_FLAG_EN
  output logic             overflow,
`endif
  output logic [DW-1:0]    avg
);
  logic [DW-1:0]    w_lane [LANES];
  logic [DW-1:0]    w_bank_rd [LANES];
  logic [ACC_W-1:0] w_beat_sum;
  logic [DW-1:0]    w_avg_calc;
  logic             w_wr;

  state_t           r_state, w_state_nx;
  logic [PTR_W-1:0] r_ptr, w_ptr_nx;
  logic [ACC_W-1:0] r_acc, w_acc_nx;
  logic             r_done, w_done_nx;
  logic             r_pend, w_pend_nx;
  logic [DW-1:0]    r_avg;
  logic [2:0]       r_rd_lane;
  logic             r_rd_valid;

  assign w_lane[0] = in0;
  assign w_lane[1] = in1;
  assign w_lane[2] = in2;
  assign w_lane[3] = in3;
  assign w_lane[4] = in4;
  assign w_lane[5] = in5;
  assign w_lane[6] = in6;
  assign w_lane[7] = in7;

  assign w_wr = in_valid && !clear && (r_state == IDLE || r_state == CAPTURE);

  always_comb begin
    w_beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) w_beat_sum = w_beat_sum + ACC_W'(w_lane[k]);
  end

  assign w_avg_calc = DW'(({1'b0, r_acc} + (ACC_W + 1)'(RND)) >> AVG_SH);

  // FINISH arms r_pend; avg/done load one edge later (last beat at k -> visible after k+2).
  // acc is frozen in DONE, so the average is taken from r_acc at that second edge.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_acc_nx   = r_acc;
    w_done_nx  = r_done;
    w_pend_nx  = 1'b0;
    if (r_pend) w_done_nx = 1'b1;
    case (r_state)
      IDLE:    if (w_wr) w_state_nx = CAPTURE;
      CAPTURE: if (w_wr && r_ptr == PTR_W'(DEPTH - 1)) w_state_nx = FINISH;
      FINISH: begin
        w_state_nx = DONE;
        w_pend_nx  = 1'b1;
      end
      DONE:    w_state_nx = DONE;
      default: w_state_nx = IDLE;
    endcase
    if (w_wr) begin
      w_ptr_nx = r_ptr + 1'b1;
      w_acc_nx = r_acc + w_beat_sum;
    end
    if (clear) begin
      w_state_nx = IDLE;
      w_ptr_nx   = '0;
      w_acc_nx   = '0;
      w_done_nx  = 1'b0;
      w_pend_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      r_avg   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_acc   <= w_acc_nx;
      r_done  <= w_done_nx;
      r_pend  <= w_pend_nx;
      if (r_pend) r_avg <= w_avg_calc;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    lane_bank #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_bank (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_wr_en   (w_wr),
      .i_wr_addr (r_ptr),
      .i_wr_data (w_lane[g]),
      .i_rd_en   (rd_en && (rd_lane == 3'(g))),
      .i_rd_addr (rd_addr),
      .o_rd_data (w_bank_rd[g])
    );
  end

  // Only the selected bank reloads, so remembering the last lane gives hold semantics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_lane  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_lane <= rd_lane;
    end
  end

  assign rd_data  = w_bank_rd[r_rd_lane];
  assign rd_valid = r_rd_valid;
  assign done     = r_done;
  assign avg      = r_avg;

`ifdef OVF_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (in_valid && (r_state == FINISH || r_state == DONE)) r_ovf <= 1'b1;
  end
  assign overflow = r_ovf;
`endif
endmodule

// File: tb/tb_lane_capture.sv
// Self-checking bench for lane_capture: directed frames plus randomized traffic
// compared each cycle against a frame-level reference model.
module tb_lane_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_lane = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] lane [8];
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [7:0] avg;
`ifdef OVF_FLAG_EN
  logic       overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_mem [8][32];
  int m_cnt, m_sum, m_cd, m_pend, m_avg, m_done, m_rd, m_rdv, m_ovf;

  always #5 clk = ~clk;

  lane_capture dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in0      (lane[0]),
    .in1      (lane[1]),
    .in2      (lane[2]),
    .in3      (lane[3]),
    .in4      (lane[4]),
    .in5      (lane[5]),
    .in6      (lane[6]),
    .in7      (lane[7]),
    .clear    (clear),
    .rd_en    (rd_en),
    .rd_lane  (rd_lane),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
`ifdef OVF_FLAG_EN
    .overflow (overflow),
`endif
    .avg      (avg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame model: count of beats collected, their sum, and a countdown to publication.
  task automatic model_step(input bit v, input bit clr, input bit re, input int rl, input int ra, input bit rs);
    if (rs) begin
      m_cnt = 0; m_sum = 0; m_cd = 0; m_done = 0; m_avg = 0;
      m_rd = 0; m_rdv = 0; m_ovf = 0;
    end else begin
      m_rdv = re;
      if (re) m_rd = m_mem[rl][ra];
      if (v && m_cnt == 32) m_ovf = 1;
      if (m_cd == 1) begin
        m_avg = m_pend;
        m_done = clr ? 0 : 1;
        m_cd = 0;
      end else if (m_cd == 2) begin
        m_cd = clr ? 0 : 1;
      end
      if (clr) begin
        m_cnt = 0; m_sum = 0; m_done = 0;
      end else if (v && m_cnt < 32) begin
        for (int k = 0; k < 8; k++) begin
          m_mem[k][m_cnt] = lane[k];
          m_sum += lane[k];
        end
        m_cnt++;
        if (m_cnt == 32) begin
          m_cd = 2;
          m_pend = (m_sum + 128) / 256;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input bit clr, input bit re, input int rl, input int ra, input bit rs);
    in_valid = v; clear = clr; rd_en = re;
    rd_lane = 3'(rl); rd_addr = 5'(ra); rst = rs;
    @(posedge clk);
    model_step(v, clr, re, rl, ra, rs);
    #1;
    check("done", 32'(done), 32'(m_done));
    check("avg", 32'(avg), 32'(m_avg));
    check("rd_valid", 32'(rd_valid), 32'(m_rdv));
    check("rd_data", 32'(rd_data), 32'(m_rd));
`ifdef OVF_FLAG_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
`endif
    in_valid = 1'b0; clear = 1'b0; rd_en = 1'b0; rst = 1'b0;
  endtask

  task automatic set_all(input int x);
    for (int k = 0; k < 8; k++) lane[k] = 8'(x);
  endtask

  initial begin
    set_all(0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_done", 32'(done), 0);
    check("rst_avg", 32'(avg), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);

    // All lanes 100
    set_all(100);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_done_k1", 32'(done), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_done_k2", 32'(done), 1);
    check("t1_avg", 32'(avg), 100);
    cyc(0, 0, 1, 3, 31, 0);
    check("t1_rd", 32'(rd_data), 100);
    check("t1_rdv", 32'(rd_valid), 1);

    // Ramp: beat n carries n on every lane
    cyc(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 32; n++) begin
      set_all(n);
      cyc(1, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t2_avg", 32'(avg), 16);
    cyc(0, 0, 1, 7, 17, 0);
    check("t2_rd", 32'(rd_data), 17);

    // Full-scale with gaps
    cyc(0, 1, 0, 0, 0, 0);
    set_all(255);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    check("t3_done_k1", 32'(done), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t3_done_k2", 32'(done), 1);
    check("t3_avg", 32'(avg), 255);

    // Aborted partial frame, then frame of ones
    cyc(0, 1, 0, 0, 0, 0);
    set_all(50);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    set_all(1);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t4_avg", 32'(avg), 1);
    cyc(0, 0, 1, 0, 5, 0);
    check("t4_rd", 32'(rd_data), 1);

    // clear with in_valid in IDLE drops the beat
    cyc(0, 1, 0, 0, 0, 0);
    set_all(200);
    cyc(1, 1, 0, 0, 0, 0);
    set_all(2);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t5_avg", 32'(avg), 2);
    cyc(0, 0, 1, 4, 0, 0);
    check("t5_rd", 32'(rd_data), 2);

    // Extra beats after done are ignored
    set_all(9);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    check("t6_avg", 32'(avg), 2);
    check("t6_done", 32'(done), 1);
    cyc(0, 0, 1, 1, 0, 0);
    check("t6_rd", 32'(rd_data), 2);
`ifdef OVF_FLAG_EN
    check("t6_ovf", 32'(overflow), 1);
`endif
    cyc(0, 1, 0, 0, 0, 0);
    check("t6_clr_done", 32'(done), 0);
    check("t6_clr_avg", 32'(avg), 2);
`ifdef OVF_FLAG_EN
    check("t6_ovf_clr", 32'(overflow), 1);
`endif

    // Randomized traffic with rare clears and one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 8; k++) lane[k] = 8'($urandom_range(0, 255));
      cyc(($urandom % 3) != 0, ($urandom % 60) == 0, $urandom % 2,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), i == 700);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
